// File: rtl/bw_window_buffer_if.sv
// Handshake bundle for the 3x3 window generator: pixel stream in, window stream out.
// The design drives the slave side; the upstream/downstream environment drives master.
interface bw_window_buffer_if #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic                  in_valid;
    logic [PIX_W-1:0]      in_pixel;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [9*PIX_W-1:0]    out_window;
    logic [COL_W-1:0]      out_col;
    logic [ROW_W-1:0]      out_row;
    logic                  frame_done;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_window, out_col, out_row, frame_done
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_window, out_col, out_row, frame_done
    );
endinterface

// File: rtl/bw_window_buffer.sv
// Streaming 3x3 neighbourhood generator: two line memories plus a column shift array,
// emitting one window per interior pixel in raster order of centres.
module bw_window_buffer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    bw_window_buffer_if.slave  bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [1:0]         phase;
    logic               accept;
    logic               last_col;
    logic               last_pix;

    logic [PIX_W-1:0]   line1 [IMG_WIDTH];
    logic [PIX_W-1:0]   line2 [IMG_WIDTH];
    logic [PIX_W-1:0]   rd1;
    logic [PIX_W-1:0]   rd2;

    // Only the middle and right columns are kept; the left column of the next
    // window is the current middle column, so the oldest column needs no storage.
    logic [3*PIX_W-1:0] col_mid;
    logic [3*PIX_W-1:0] col_rgt;
    logic [3*PIX_W-1:0] col_new;
    logic [9*PIX_W-1:0] next_win;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign rd1      = line1[col];
    assign rd2      = line2[col];
    assign col_new  = {bus.in_pixel, rd1, rd2};
    assign last_col = (col == LAST_COL);
    assign last_pix = last_col && (row == LAST_ROW);

    always_comb begin
        if (row < ROW_W'(2)) begin
            phase = ST_FILL;
        end else if (col < COL_W'(2)) begin
            phase = ST_PRIME;
        end else begin
            phase = ST_EMIT;
        end
    end

    always_comb begin
        next_win = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            next_win[PIX_W*(3*r)   +: PIX_W] = col_mid[PIX_W*r +: PIX_W];
            next_win[PIX_W*(3*r+1) +: PIX_W] = col_rgt[PIX_W*r +: PIX_W];
            next_win[PIX_W*(3*r+2) +: PIX_W] = col_new[PIX_W*r +: PIX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line2[col] <= line1[col];
            line1[col] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_pix) begin
                col <= '0;
                row <= '0;
            end else if (last_col) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_mid <= '0;
            col_rgt <= '0;
        end else if (accept) begin
            col_mid <= col_rgt;
            col_rgt <= col_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_window <= '0;
            bus.out_col    <= '0;
            bus.out_row    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= accept && last_pix;
            if (accept && (phase == ST_EMIT)) begin
                bus.out_valid  <= 1'b1;
                bus.out_window <= next_win;
                bus.out_col    <= col - COL_W'(1);
                bus.out_row    <= row - ROW_W'(1);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
